// File: rtl/adc_sample_averager.sv
// adc_sample_averager: groups ADC samples into 2^LOG2N windows and emits truncated mean, min, max and a hysteresis alarm
//   clk, rst_i               clock, synchronous active-high reset
//   in_valid, in_data        sample strobe and reading
//   flush                    abort current window and restart settling
//   out_valid                one-cycle pulse when results update
//   out_avg/out_min/out_max  window mean (truncated), minimum, maximum
//   alarm                    hysteresis flag on out_avg
//   out_windows              emitted window count, wraps at 2^16
module adc_sample_averager #(
  parameter int WIDTH     = 14,
  parameter int LOG2N     = 4,
  parameter int SKIP      = 1,
  parameter int THRESH_HI = 8192,
  parameter int THRESH_LO = 7680
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_avg,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic             alarm,
  output logic [15:0]      out_windows
);
  typedef enum logic {S_SKIP = 1'b0, S_ACC = 1'b1} state_t;
  localparam state_t S_INIT = state_t'(SKIP == 0);
  localparam int AW = WIDTH + LOG2N;
  state_t r_state;
  logic [1:0] r_skip_cnt;
  logic [AW-1:0] r_acc;
  logic [LOG2N-1:0] r_cnt;
  logic [WIDTH-1:0] r_min, r_max;
  logic w_take, w_last;
  logic [AW-1:0] w_sum;
  logic [WIDTH-1:0] w_avg, w_min, w_max;
  assign w_take = in_valid && !flush;
  assign w_last = w_take && (r_cnt == '1);
  assign w_sum  = r_acc + AW'(in_data);
  // results include the last sample, so they are formed from the pre-update window state plus in_data
  assign w_avg  = w_sum[AW-1:LOG2N];
  assign w_min  = (in_data < r_min) ? in_data : r_min;
  assign w_max  = (in_data > r_max) ? in_data : r_max;
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state     <= S_INIT;
      r_skip_cnt  <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_min       <= '1;
      r_max       <= '0;
      out_valid   <= 1'b0;
      out_avg     <= '0;
      out_min     <= '0;
      out_max     <= '0;
      alarm       <= 1'b0;
      out_windows <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        r_state    <= S_INIT;
        r_skip_cnt <= '0;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_min      <= '1;
        r_max      <= '0;
      end else if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_min <= '1;
        r_max <= '0;
        if (r_state == S_SKIP) begin
          r_skip_cnt <= r_skip_cnt + 2'd1;
          if (int'(r_skip_cnt) + 1 >= SKIP) r_state <= S_ACC;
        end else begin
          out_valid   <= 1'b1;
          out_avg     <= w_avg;
          out_min     <= w_min;
          out_max     <= w_max;
          out_windows <= out_windows + 16'd1;
          alarm       <= (w_avg >= WIDTH'(THRESH_HI)) ? 1'b1 : (w_avg <= WIDTH'(THRESH_LO)) ? 1'b0 : alarm;
        end
      end else if (w_take) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
        r_min <= w_min;
        r_max <= w_max;
      end
    end
  end
endmodule
